// File: rtl/time_pkg.sv
// Shared mode encoding and time-field limits for the time-setting controller.
package time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2
    } mode_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

endpackage

// File: rtl/wrap_cnt.sv
// Generic modulo counter: counts 0..limit, wraps to 0 and flags carry on the wrapping increment.
module wrap_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] r_value;

    // Clear wins over increment, so a clearing edge never propagates a carry.
    assign carry = inc && !clr && (r_value == limit);
    assign value = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value == limit) ? '0 : r_value + 1'b1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Clock with RUN / SET_HOUR / SET_MIN modes; optional field blink under TIME_SET_BLINK_EN.
// Handshake: tick_1ms, key_mode and key_inc are single-cycle pulses sampled on the rising edge; no backpressure.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1ms,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hour,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]    r_mode;
    logic [1:0]    w_mode_next;
    logic          w_pre_inc;
    logic          w_pre_clr;
    logic          w_sec_inc;
    logic          w_min_inc;
    logic          w_hour_inc;
    logic          w_pre_carry;
    logic          w_sec_carry;
    logic          w_min_carry;
    logic          w_unused_day_wrap;
    logic [PW-1:0] w_pre_value;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_RUN;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Next-state logic; the unused encoding falls back to RUN
    always_comb begin
        w_mode_next = r_mode;
        case (r_mode)
            MODE_RUN:      if (key_mode) w_mode_next = MODE_SET_HOUR;
            MODE_SET_HOUR: if (key_mode) w_mode_next = MODE_SET_MIN;
            MODE_SET_MIN:  if (key_mode) w_mode_next = MODE_RUN;
            default:       w_mode_next = MODE_RUN;
        endcase
    end

    // Output logic: key_mode always wins over ticks and increments in the same cycle
    always_comb begin
        w_pre_inc  = 1'b0;
        w_pre_clr  = 1'b0;
        w_sec_inc  = 1'b0;
        w_min_inc  = 1'b0;
        w_hour_inc = 1'b0;
        case (r_mode)
            MODE_RUN: begin
                w_pre_inc  = tick_1ms && !key_mode;
                w_sec_inc  = w_pre_carry;
                w_min_inc  = w_sec_carry;
                w_hour_inc = w_min_carry;
            end
            MODE_SET_HOUR: begin
                w_hour_inc = key_inc && !key_mode;
            end
            MODE_SET_MIN: begin
                w_min_inc = key_inc && !key_mode;
                w_pre_clr = key_mode;
            end
            default: ;
        endcase
    end

    wrap_cnt #(.W(PW)) u_pre (
        .clk(clk), .rst_n(rst_n), .inc(w_pre_inc), .clr(w_pre_clr),
        .limit(PW'(TICK_DIV - 1)), .value(w_pre_value), .carry(w_pre_carry)
    );

    wrap_cnt #(.W(6)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(w_sec_inc), .clr(w_pre_clr),
        .limit(SEC_MAX), .value(sec), .carry(w_sec_carry)
    );

    // Minute carry only matters in RUN; a set-mode wrap must not touch the hour.
    wrap_cnt #(.W(6)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(w_min_inc), .clr(1'b0),
        .limit(MIN_MAX), .value(min), .carry(w_min_carry)
    );

    wrap_cnt #(.W(5)) u_hour (
        .clk(clk), .rst_n(rst_n), .inc(w_hour_inc), .clr(1'b0),
        .limit(HOUR_MAX), .value(hour), .carry(w_unused_day_wrap)
    );

    assign mode = r_mode;

`ifdef TIME_SET_BLINK_EN
    localparam int HALF = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic          r_blink;
    logic          w_mode_chg;
    logic          w_in_set;
    logic          w_blink_inc;
    logic          w_blink_carry;
    logic [BW-1:0] w_blink_cnt;

    assign w_mode_chg  = (r_mode != w_mode_next);
    assign w_in_set    = (r_mode == MODE_SET_HOUR) || (r_mode == MODE_SET_MIN);
    assign w_blink_inc = w_in_set && tick_1ms && !w_mode_chg;

    wrap_cnt #(.W(BW)) u_blink_cnt (
        .clk(clk), .rst_n(rst_n), .inc(w_blink_inc), .clr(w_mode_chg || !w_in_set),
        .limit(BW'(HALF - 1)), .value(w_blink_cnt), .carry(w_blink_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink <= 1'b1;
        end else if (w_mode_chg || !w_in_set) begin
            r_blink <= 1'b1;
        end else if (w_blink_carry) begin
            r_blink <= ~r_blink;
        end
    end

    assign blink = r_blink;
`else
    assign blink = 1'b1;
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl (TICK_DIV=4): directed scenarios then random pulses against a seconds-of-day model.
module tb_time_set_ctrl;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       tick_1ms;
    logic       key_mode;
    logic       key_inc;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic [1:0] mode;
    logic       blink;

    int n_checks;
    int n_fail;

    // Reference model: time as seconds of day, milliseconds counted toward the next second
    int m_t;
    int m_ms;
    int m_mode;
    int m_bcnt;
    int m_blink;

    time_set_ctrl #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .key_mode(key_mode),
        .key_inc(key_inc), .sec(sec), .min(min), .hour(hour), .mode(mode), .blink(blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sec"},   32'(sec),   32'(m_t % 60));
        chk({tag, ".min"},   32'(min),   32'((m_t / 60) % 60));
        chk({tag, ".hour"},  32'(hour),  32'(m_t / 3600));
        chk({tag, ".mode"},  32'(mode),  32'(m_mode));
        chk({tag, ".blink"}, 32'(blink), 32'(m_blink));
    endtask

    task automatic model_reset();
        m_t = 0; m_ms = 0; m_mode = 0; m_bcnt = 0; m_blink = 1;
    endtask

    task automatic model_step(input bit tk, input bit km, input bit ki);
        int h, mi, s;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (km) begin
            if (m_mode == 2) begin
                m_ms = 0;
                s    = 0;
            end
            m_mode  = (m_mode + 1) % 3;
            m_blink = 1;
            m_bcnt  = 0;
            m_t     = h * 3600 + mi * 60 + s;
        end else if (m_mode == 0) begin
            if (tk) begin
                m_ms++;
                if (m_ms == TD) begin
                    m_ms = 0;
                    m_t  = (m_t + 1) % 86400;
                end
            end
        end else begin
            if (ki && m_mode == 1) h  = (h + 1) % 24;
            if (ki && m_mode == 2) mi = (mi + 1) % 60;
            m_t = h * 3600 + mi * 60 + s;
`ifdef TIME_SET_BLINK_EN
            if (tk) begin
                m_bcnt++;
                if (m_bcnt == TD / 2) begin
                    m_bcnt  = 0;
                    m_blink = 1 - m_blink;
                end
            end
`endif
        end
    endtask

    // Entered one time unit after a rising edge; leaves at the same phase one cycle later
    task automatic step(input bit tk, input bit km, input bit ki, input string tag);
        tick_1ms = tk; key_mode = km; key_inc = ki;
        @(posedge clk);
        model_step(tk, km, ki);
        #1;
        tick_1ms = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
        check_all(tag);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, tag);
    endtask

    task automatic incs(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        tick_1ms = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // First second after reset
        ticks(TD, "first_sec");
        chk("first_sec.explicit", 32'(sec), 32'd1);

        // Hour and minute setting with wrap and no cross-field carry
        step(1'b0, 1'b1, 1'b0, "to_set_hour");
        incs(25, "inc_hour");
        chk("hour_after_25", 32'(hour), 32'd1);
        step(1'b0, 1'b1, 1'b0, "to_set_min");
        incs(61, "inc_min");
        chk("min_after_61", 32'(min), 32'd1);
        chk("hour_kept", 32'(hour), 32'd1);
        chk("mode_set_min", 32'(mode), 32'd2);

        // Preload 23:59:59 then roll over the whole day
        step(1'b0, 1'b1, 1'b0, "to_run");
        step(1'b0, 1'b1, 1'b0, "to_set_hour2");
        incs(22, "inc_hour2");
        step(1'b0, 1'b1, 1'b0, "to_set_min2");
        incs(58, "inc_min2");
        step(1'b0, 1'b1, 1'b0, "to_run2");
        ticks(59 * TD, "fill_sec");
        chk("pre_wrap.sec", 32'(sec), 32'd59);
        ticks(TD - 1, "pre_wrap_hold");
        chk("pre_wrap.hour", 32'(hour), 32'd23);
        ticks(1, "day_wrap");
        chk("day_wrap.all", 32'({hour, min, sec}), 32'd0);

        // sec=30, ticks frozen in set modes, sec and prescaler cleared on return to RUN
        ticks(30 * TD, "to_sec30");
        step(1'b1, 1'b1, 1'b0, "tick_with_mode");
        step(1'b0, 1'b1, 1'b0, "to_set_min3");
        chk("frozen.sec_before", 32'(sec), 32'd30);
        ticks(10, "frozen_ticks");
        chk("frozen.sec_after", 32'(sec), 32'd30);
        step(1'b0, 1'b1, 1'b0, "back_run");
        chk("back_run.sec", 32'(sec), 32'd0);
        ticks(TD - 1, "presc_cleared");
        chk("presc_cleared.sec", 32'(sec), 32'd0);
        ticks(1, "presc_first");

        // Combined key_mode+key_inc in RUN, then blink behaviour in SET_HOUR
        step(1'b0, 1'b1, 1'b1, "mode_and_inc");
        chk("mode_and_inc.mode", 32'(mode), 32'd1);
        ticks(6, "blink_ticks");
        incs(3, "hour_more");

        // Asynchronous reset mid SET_HOUR, away from any clock edge
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(TD, "post_reset_sec");

        // Random pulses
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
